// File: rtl/mem_requester.sv
// mem_requester: initiator-side front end for the memory interface.
// Arbitrates between the instruction-fetch port and the data load/store port,
// runs one memory access at a time for WAIT_CYCLES cycles, and returns a
// single-cycle response pulse to whichever port owned the access.
// Optional feature: define MEM_REQUESTER_RR_ARB_EN for round-robin arbitration;
// without it, data always wins over instruction.
module mem_requester #(
  parameter int MEM_WIDTH   = 32,
  parameter int MEM_SIZE    = 256,
  parameter int WAIT_CYCLES = 1,
  localparam int AW         = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  input  logic [AW-1:0]        i_req_addr,
  output logic                 i_req_ready,
  output logic                 i_rsp_valid,
  output logic [MEM_WIDTH-1:0] i_rsp_data,
  input  logic                 d_req_valid,
  input  logic                 d_req_write,
  input  logic [AW-1:0]        d_req_addr,
  input  logic [MEM_WIDTH-1:0] d_req_wdata,
  output logic                 d_req_ready,
  output logic                 d_rsp_valid,
  output logic [MEM_WIDTH-1:0] d_rsp_data,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  input  logic [MEM_WIDTH-1:0] mem_read_val,
  output logic [MEM_WIDTH-1:0] mem_write_val
);

  // The wait counter starts at WAIT_CYCLES-1 so the enables stay up exactly
  // WAIT_CYCLES cycles (legal range 1..15 fits in four bits).
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state;
  state_t                 state_next;
  logic   [3:0]           wait_cnt;
  logic                   owner_d;
  logic                   write_q;
  logic   [AW-1:0]        addr_q;
  logic   [MEM_WIDTH-1:0] wdata_q;
  logic   [MEM_WIDTH-1:0] i_data_q;
  logic   [MEM_WIDTH-1:0] d_data_q;
  logic                   grant_d;
  logic                   grant_i;
  logic                   accept_d;
  logic                   accept_i;

`ifdef MEM_REQUESTER_RR_ARB_EN
  logic prefer_d;

  // Round-robin choice: the preferred port wins a tie, otherwise whoever is valid.
  always_comb begin
    grant_d  = d_req_valid && (prefer_d || !i_req_valid);
    grant_i  = i_req_valid && !grant_d;
    accept_d = rst_n && (state == IDLE) && grant_d;
    accept_i = rst_n && (state == IDLE) && grant_i;
  end

  // After each grant the preference moves to the port that was not served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prefer_d <= 1'b1;
    end else if (accept_d || accept_i) begin
      prefer_d <= accept_i;
    end
  end
`else
  // Fixed priority: a valid data request always beats a fetch.
  always_comb begin
    grant_d  = d_req_valid;
    grant_i  = i_req_valid && !d_req_valid;
    accept_d = rst_n && (state == IDLE) && grant_d;
    accept_i = rst_n && (state == IDLE) && grant_i;
  end
`endif

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> ACCESS on accept, ACCESS -> RESP when the wait expires, RESP -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_d || accept_i) state_next = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0)     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latching, wait counting and read-data capture into the owner's register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
      owner_d  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_data_q <= '0;
      d_data_q <= '0;
    end else if (accept_d || accept_i) begin
      wait_cnt <= CNT_INIT;
      owner_d  <= accept_d;
      write_q  <= accept_d && d_req_write;
      addr_q   <= accept_d ? d_req_addr : i_req_addr;
      if (accept_d) begin
        wdata_q <= d_req_wdata;
      end
    end else if (state == ACCESS) begin
      if (wait_cnt == 4'd0) begin
        if (!write_q) begin
          if (owner_d) begin
            d_data_q <= mem_read_val;
          end else begin
            i_data_q <= mem_read_val;
          end
        end
      end else begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Outputs decoded from state and latched registers only, except the combinational ready.
  always_comb begin
    i_req_ready   = accept_i;
    d_req_ready   = accept_d;
    mem_read_en   = (state == ACCESS) && !write_q;
    mem_write_en  = (state == ACCESS) && write_q;
    i_rsp_valid   = (state == RESP) && !owner_d;
    d_rsp_valid   = (state == RESP) && owner_d;
    mem_addr      = addr_q;
    mem_write_val = wdata_q;
    i_rsp_data    = i_data_q;
    d_rsp_data    = d_data_q;
  end

endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: drives two mem_requester instances (WAIT_CYCLES 1 and 3)
// with the same directed stimulus and checks both against a cycle model that
// tracks each access by the number of cycles elapsed since its acceptance.
module tb_mem_requester;

  localparam int MW = 32;
  localparam int AW = 8;

  logic          clk;
  logic          rst_n;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          d_req_valid;
  logic          d_req_write;
  logic [AW-1:0] d_req_addr;
  logic [MW-1:0] d_req_wdata;
  logic [MW-1:0] mem_read_val;

  logic          i_ready [2];
  logic          d_ready [2];
  logic          i_rv    [2];
  logic          d_rv    [2];
  logic          rd_en   [2];
  logic          wr_en   [2];
  logic [MW-1:0] i_data  [2];
  logic [MW-1:0] d_data  [2];
  logic [MW-1:0] wval    [2];
  logic [AW-1:0] maddr   [2];

  // Model state: el = cycles since acceptance (-1 when idle)
  int            el    [2];
  bit            ownD  [2];
  bit            wrQ   [2];
  bit            ptrD  [2];
  logic [AW-1:0] adQ   [2];
  logic [MW-1:0] wdQ   [2];
  logic [MW-1:0] irQ   [2];
  logic [MW-1:0] drQ   [2];
  int            gCyc  [2][64];
  bit            gD    [2][64];
  int            gN    [2];
  int            cyc;
  bit            modelLive;
  int            checks;
  int            errors;

  mem_requester #(.MEM_WIDTH(MW), .MEM_SIZE(256), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_ready[0]),
    .i_rsp_valid(i_rv[0]), .i_rsp_data(i_data[0]),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_ready[0]),
    .d_rsp_valid(d_rv[0]), .d_rsp_data(d_data[0]),
    .mem_addr(maddr[0]), .mem_read_en(rd_en[0]), .mem_write_en(wr_en[0]),
    .mem_read_val(mem_read_val), .mem_write_val(wval[0])
  );

  mem_requester #(.MEM_WIDTH(MW), .MEM_SIZE(256), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_ready[1]),
    .i_rsp_valid(i_rv[1]), .i_rsp_data(i_data[1]),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_ready[1]),
    .d_rsp_valid(d_rv[1]), .d_rsp_data(d_data[1]),
    .mem_addr(maddr[1]), .mem_read_en(rd_en[1]), .mem_write_en(wr_en[1]),
    .mem_read_val(mem_read_val), .mem_write_val(wval[1])
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waitOf(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit expReadyD(int k);
    bit win;
`ifdef MEM_REQUESTER_RR_ARB_EN
    win = ptrD[k] || !i_req_valid;
`else
    win = 1'b1;
`endif
    return rst_n && (el[k] < 0) && d_req_valid && win;
  endfunction

  function automatic bit expReadyI(int k);
    return rst_n && (el[k] < 0) && i_req_valid && !expReadyD(k);
  endfunction

  task automatic checkOutput(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(bit iv, logic [AW-1:0] ia, bit dv, bit dw,
                               logic [AW-1:0] da, logic [MW-1:0] dwd, logic [MW-1:0] rv);
    i_req_valid  = iv;
    i_req_addr   = ia;
    d_req_valid  = dv;
    d_req_write  = dw;
    d_req_addr   = da;
    d_req_wdata  = dwd;
    mem_read_val = rv;
  endtask

  task automatic compareAll(int k);
    int  w;
    bit  act;
    w   = waitOf(k);
    act = (el[k] >= 1) && (el[k] <= w);
    checkOutput("i_req_ready",   k, 32'(i_ready[k]), 32'(expReadyI(k)));
    checkOutput("d_req_ready",   k, 32'(d_ready[k]), 32'(expReadyD(k)));
    checkOutput("mem_read_en",   k, 32'(rd_en[k]),   32'(act && !wrQ[k]));
    checkOutput("mem_write_en",  k, 32'(wr_en[k]),   32'(act && wrQ[k]));
    checkOutput("i_rsp_valid",   k, 32'(i_rv[k]),    32'((el[k] == w + 1) && !ownD[k]));
    checkOutput("d_rsp_valid",   k, 32'(d_rv[k]),    32'((el[k] == w + 1) && ownD[k]));
    checkOutput("mem_addr",      k, 32'(maddr[k]),   32'(adQ[k]));
    checkOutput("mem_write_val", k, wval[k],         wdQ[k]);
    checkOutput("i_rsp_data",    k, i_data[k],       irQ[k]);
    checkOutput("d_rsp_data",    k, d_data[k],       drQ[k]);
  endtask

  task automatic updateModel(int k);
    int w;
    bit gd;
    bit gi;
    w  = waitOf(k);
    gd = expReadyD(k);
    gi = expReadyI(k);
    if (!rst_n) begin
      el[k]   = -1;
      ownD[k] = 1'b0;
      wrQ[k]  = 1'b0;
      adQ[k]  = '0;
      wdQ[k]  = '0;
      irQ[k]  = '0;
      drQ[k]  = '0;
      ptrD[k] = 1'b1;
    end else if (el[k] < 0) begin
      if (gd || gi) begin
        el[k]   = 1;
        ownD[k] = gd;
        wrQ[k]  = gd && d_req_write;
        adQ[k]  = gd ? d_req_addr : i_req_addr;
        if (gd) wdQ[k] = d_req_wdata;
        ptrD[k] = gi;
        gCyc[k][gN[k]] = cyc;
        gD[k][gN[k]]   = gd;
        if (gN[k] < 63) gN[k]++;
      end
    end else if (el[k] == w) begin
      if (!wrQ[k]) begin
        if (ownD[k]) drQ[k] = mem_read_val;
        else         irQ[k] = mem_read_val;
      end
      el[k] = w + 1;
    end else if (el[k] == w + 1) begin
      el[k] = -1;
    end else begin
      el[k]++;
    end
  endtask

  // One clock cycle: compare mid-cycle, advance the model on the edge, return at the falling edge.
  task automatic tick();
    #2;
    if (modelLive) begin
      for (int k = 0; k < 2; k++) compareAll(k);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) updateModel(k);
    if (!rst_n) modelLive = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(logic [MW-1:0] rv);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, rv);
  endtask

  // Directed scenarios; every cycle is also compared against the model inside tick().
  initial begin
    bit expD;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    modelLive = 1'b0;
    gN[0]     = 0;
    gN[1]     = 0;
    rst_n     = 1'b0;
    idle('0);
    repeat (2) tick();
    rst_n = 1'b1;
    checkOutput("reset_mem_addr",   1, 32'(maddr[1]), 32'h0);
    checkOutput("reset_d_rsp_data", 1, d_data[1],     32'h0);
    checkOutput("reset_rd_en",      0, 32'(rd_en[0]), 32'h0);

    // Fetch 0x10 returning 0xDEADBEEF
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, '0, '0, 32'hDEADBEEF);
    #1 checkOutput("fetch_ready_n", 0, 32'(i_ready[0]), 32'h1);
    tick();
    idle(32'hDEADBEEF);
    #1 checkOutput("fetch_rd_en_n1", 0, 32'(rd_en[0]), 32'h1);
    tick();
    #1;
    checkOutput("fetch_rsp_n2",    0, 32'(i_rv[0]),  32'h1);
    checkOutput("fetch_data_n2",   0, i_data[0],     32'hDEADBEEF);
    checkOutput("fetch_rd_off_n2", 0, 32'(rd_en[0]), 32'h0);
    repeat (5) tick();

    // Store 0x20 <- 0x12345678
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 8'h20, 32'h12345678, 32'hCAFEF00D);
    tick();
    idle(32'hCAFEF00D);
    #1;
    checkOutput("store_wr_en",  1, 32'(wr_en[1]), 32'h1);
    checkOutput("store_addr",   1, 32'(maddr[1]), 32'h20);
    checkOutput("store_wval",   1, wval[1],       32'h12345678);
    repeat (3) tick();
    #1;
    checkOutput("store_rsp_n4",  1, 32'(d_rv[1]), 32'h1);
    checkOutput("store_data_n4", 1, d_data[1],    32'h0);
    repeat (3) tick();

    // Load 0x30 returning 0xA5A55A5A
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 8'h30, '0, 32'hA5A55A5A);
    tick();
    idle(32'hA5A55A5A);
    repeat (6) tick();
    checkOutput("load_data", 1, d_data[1], 32'hA5A55A5A);

    // Both ports valid continuously, starting from a fresh reset
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    gN[0] = 0;
    gN[1] = 0;
    applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 8'h50, '0, 32'h11112222);
    for (int n = 0; n < 100 && gN[1] < 4; n++) tick();
    checkOutput("arb_grant_count", 1, 32'(gN[1]), 32'd4);
    idle(32'h11112222);
    repeat (8) tick();
    for (int j = 0; j < 4; j++) begin
`ifdef MEM_REQUESTER_RR_ARB_EN
      expD = (j % 2 == 0);
`else
      expD = 1'b1;
`endif
      checkOutput("arb_owner_is_data", 1, 32'(gD[1][j]), 32'(expD));
    end
    for (int j = 0; j < 3; j++) begin
      checkOutput("arb_spacing_w3", 1, 32'(gCyc[1][j+1] - gCyc[1][j]), 32'd5);
      checkOutput("arb_spacing_w1", 0, 32'(gCyc[0][j+1] - gCyc[0][j]), 32'd3);
    end

    // Fetch held high while a load is in progress
    gN[0] = 0;
    gN[1] = 0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 8'h60, '0, 32'h0BADF00D);
    tick();
    applyStimulus(1'b1, 8'h70, 1'b0, 1'b0, '0, '0, 32'h0BADF00D);
    for (int n = 0; n < 20 && gN[1] < 2; n++) tick();
    checkOutput("held_grant_count", 1, 32'(gN[1]), 32'd2);
    idle(32'h0BADF00D);
    repeat (8) tick();
    checkOutput("held_first_data",  1, 32'(gD[1][0]), 32'h1);
    checkOutput("held_second_inst", 1, 32'(gD[1][1]), 32'h0);
    checkOutput("held_spacing",     1, 32'(gCyc[1][1] - gCyc[1][0]), 32'd5);

    // Reset during access cycle 2 of 3, then a fresh fetch
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, '0, '0, 32'h77778888);
    tick();
    idle(32'h77778888);
    tick();
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h48, 1'b0, 1'b0, '0, '0, 32'h77778888);
    tick();
    #1;
    checkOutput("rst_rd_en_off", 1, 32'(rd_en[1]),   32'h0);
    checkOutput("rst_no_rsp",    1, 32'(i_rv[1]),    32'h0);
    checkOutput("rst_ready_low", 1, 32'(i_ready[1]), 32'h0);
    tick();
    #1;
    checkOutput("rst_no_rsp2",  1, 32'(i_rv[1]),  32'h0);
    checkOutput("rst_addr_0",   1, 32'(maddr[1]), 32'h0);
    checkOutput("rst_idata_0",  1, i_data[1],     32'h0);
    rst_n = 1'b1;
    tick();
    idle(32'h77778888);
    repeat (6) tick();
    checkOutput("post_rst_fetch", 1, i_data[1], 32'h77778888);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
